// File: rtl/ktop_axi_mem_responder_if.sv
// Simplified AXI4 channel bundle between a kernel mNN_axi master and the memory responder.
// No IDs, resp, burst type or size; INCR bursts of full-width beats only.
interface ktop_axi_mem_responder_if #(
   parameter int C_ADDR_WIDTH = 64,
   parameter int C_DATA_WIDTH = 32
);
   logic                      awvalid;
   logic                      awready;
   logic [C_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                awlen;
   logic                      wvalid;
   logic                      wready;
   logic [C_DATA_WIDTH-1:0]   wdata;
   logic [C_DATA_WIDTH/8-1:0] wstrb;
   logic                      wlast;
   logic                      bvalid;
   logic                      bready;
   logic                      arvalid;
   logic                      arready;
   logic [C_ADDR_WIDTH-1:0]   araddr;
   logic [7:0]                arlen;
   logic                      rvalid;
   logic                      rready;
   logic [C_DATA_WIDTH-1:0]   rdata;
   logic                      rlast;

   modport master (
      output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, rready,
      input  awready, wready, bvalid, arready, rvalid, rdata, rlast
   );

   modport slave (
      input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, rready,
      output awready, wready, bvalid, arready, rvalid, rdata, rlast
   );
endinterface

// File: rtl/ktop_axi_mem_responder.sv
// AXI4 slave memory responder: word-addressed on-chip RAM behind independent write and
// read FSMs, with beat counters and a sticky wlast-mismatch flag for kernel bring-up.
module ktop_axi_mem_responder #(
   parameter int C_ADDR_WIDTH     = 64,
   parameter int C_DATA_WIDTH     = 32,
   parameter int C_MEM_DEPTH_LOG2 = 10
) (
   input  logic                    ap_clk,
   input  logic                    areset,
   ktop_axi_mem_responder_if.slave s_axi,
   output logic [31:0]             wr_beat_count,
   output logic [31:0]             rd_beat_count,
   output logic                    err_wlast
);
   localparam int NUM_BYTES = C_DATA_WIDTH / 8;
   localparam int IDX_LSB   = $clog2(NUM_BYTES);
   localparam int IDX_MSB   = C_MEM_DEPTH_LOG2 + IDX_LSB - 1;

   typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_BURST} r_state_t;

   logic [C_DATA_WIDTH-1:0] mem [2**C_MEM_DEPTH_LOG2];

   logic [C_ADDR_WIDTH-1:0] aw_addr;
   logic [C_ADDR_WIDTH-1:0] ar_addr;
   logic                    unused_addr_bits;

   w_state_t w_state, w_state_next;
   idx_t     w_idx;
   logic [7:0] w_len;
   logic [7:0] w_cnt;
   logic     awready_c, wready_c, bvalid_c;
   logic     aw_hs, w_beat, w_last_beat;
   logic [31:0] wr_cnt_q;
   logic     err_q;

   r_state_t r_state, r_state_next;
   idx_t     r_idx;
   logic [7:0] r_len;
   logic [8:0] r_issued;
   logic     arready_c, ar_hs, r_hs, r_load;
   logic     rvalid_q, rlast_q;
   logic [C_DATA_WIDTH-1:0] rdata_q;
   logic [31:0] rd_cnt_q;

   // Only the word-index slice of each address matters; upper and sub-word bits are ignored.
   assign aw_addr          = s_axi.awaddr;
   assign ar_addr          = s_axi.araddr;
   assign unused_addr_bits = ^{aw_addr, ar_addr};

   assign aw_hs       = awready_c && s_axi.awvalid;
   assign w_beat      = wready_c && s_axi.wvalid;
   assign w_last_beat = (w_cnt == w_len);

   always_ff @(posedge ap_clk) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_state_next;
   end

   always_comb begin
      w_state_next = w_state;
      awready_c    = 1'b0;
      wready_c     = 1'b0;
      bvalid_c     = 1'b0;
      if (!areset) begin
         case (w_state)
            W_IDLE: begin
               awready_c = 1'b1;
               if (s_axi.awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
               wready_c = 1'b1;
               if (s_axi.wvalid && w_last_beat) w_state_next = W_RESP;
            end
            W_RESP: begin
               bvalid_c = 1'b1;
               if (s_axi.bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
         endcase
      end
   end

   // Burst length is taken from awlen alone; wlast is only checked against it.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         w_idx    <= '0;
         w_len    <= '0;
         w_cnt    <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (aw_hs) begin
            w_idx <= aw_addr[IDX_MSB:IDX_LSB];
            w_len <= s_axi.awlen;
            w_cnt <= '0;
         end
         if (w_beat) begin
            w_idx    <= w_idx + idx_t'(1);
            w_cnt    <= w_cnt + 8'd1;
            wr_cnt_q <= wr_cnt_q + 32'd1;
            if (s_axi.wlast != w_last_beat) err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (w_beat) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   assign ar_hs  = arready_c && s_axi.arvalid;
   assign r_hs   = !areset && rvalid_q && s_axi.rready;
   assign r_load = !areset && (r_state == R_BURST) && (!rvalid_q || s_axi.rready)
                   && (r_issued <= {1'b0, r_len});

   always_ff @(posedge ap_clk) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_state_next;
   end

   always_comb begin
      r_state_next = r_state;
      arready_c    = 1'b0;
      if (!areset) begin
         case (r_state)
            R_IDLE: begin
               arready_c = 1'b1;
               if (s_axi.arvalid) r_state_next = R_BURST;
            end
            R_BURST: begin
               if (rvalid_q && s_axi.rready && rlast_q) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
         endcase
      end
   end

   // One-deep output register: refills whenever it is empty or being drained this cycle.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_idx    <= '0;
         r_len    <= '0;
         r_issued <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (ar_hs) begin
            r_idx    <= ar_addr[IDX_MSB:IDX_LSB];
            r_len    <= s_axi.arlen;
            r_issued <= '0;
         end
         if (r_load) begin
            rdata_q  <= mem[r_idx];
            rvalid_q <= 1'b1;
            rlast_q  <= (r_issued == {1'b0, r_len});
            r_idx    <= r_idx + idx_t'(1);
            r_issued <= r_issued + 9'd1;
         end else if (r_hs) begin
            rvalid_q <= 1'b0;
         end
         if (r_hs) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
   end

   assign s_axi.awready = awready_c;
   assign s_axi.wready  = wready_c;
   assign s_axi.bvalid  = bvalid_c;
   assign s_axi.arready = arready_c;
   assign s_axi.rvalid  = rvalid_q && !areset;
   assign s_axi.rlast   = rlast_q && !areset;
   assign s_axi.rdata   = areset ? '0 : rdata_q;
   assign wr_beat_count = areset ? 32'd0 : wr_cnt_q;
   assign rd_beat_count = areset ? 32'd0 : rd_cnt_q;
   assign err_wlast     = err_q && !areset;
endmodule
